// File: rtl/fieldbuf_pkg.sv
// Shared constants and the per-buffer state encoding for the field buffer.
// Imported by fieldbuf_mem and field_buffer.
package fieldbuf_pkg;

    localparam int unsigned FB_NBUF     = 8;
    localparam int unsigned FB_NFIELD   = 32;
    localparam int unsigned FB_WIDTH    = 8;
    localparam int unsigned FB_BUFP_W   = $clog2(FB_NBUF);
    localparam int unsigned FB_FIELDP_W = $clog2(FB_NFIELD);
    localparam int unsigned FB_LEN_W    = FB_FIELDP_W + 1;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2,
        BUF_DONE    = 2'd3
    } buf_state_e;

endpackage

// File: rtl/fieldbuf_mem.sv
// Field storage: NBUF x NFIELD words, ingress and processor write ports,
// asynchronous processor and egress read ports. Contents are never reset.
module fieldbuf_mem
    import fieldbuf_pkg::*;
#(
    parameter int unsigned NBUF   = FB_NBUF,
    parameter int unsigned NFIELD = FB_NFIELD,
    parameter int unsigned WIDTH  = FB_WIDTH,
    localparam int unsigned BW    = $clog2(NBUF),
    localparam int unsigned FW    = $clog2(NFIELD)
) (
    input  logic             clk,
    input  logic             ing_we,
    input  logic [BW-1:0]    ing_buf,
    input  logic [FW-1:0]    ing_field,
    input  logic [WIDTH-1:0] ing_data,
    input  logic             prc_we,
    input  logic [BW-1:0]    prc_buf,
    input  logic [FW-1:0]    prc_field,
    input  logic [WIDTH-1:0] prc_data,
    input  logic [BW-1:0]    prd_buf,
    input  logic [FW-1:0]    prd_field,
    output logic [WIDTH-1:0] prd_data,
    input  logic [BW-1:0]    egr_buf,
    input  logic [FW-1:0]    egr_field,
    output logic [WIDTH-1:0] egr_data
);

    logic [WIDTH-1:0] mem_q [NBUF][NFIELD];

    // The two write ports never target the same buffer: ingress only writes
    // EMPTY/FILLING buffers, the processor only FULL ones.
    always_ff @(posedge clk) begin
        if (ing_we) begin
            mem_q[ing_buf][ing_field] <= ing_data;
        end
        if (prc_we) begin
            mem_q[prc_buf][prc_field] <= prc_data;
        end
    end

    assign prd_data = mem_q[prd_buf][prd_field];
    assign egr_data = mem_q[egr_buf][egr_field];

endmodule

// File: rtl/field_buffer.sv
// Ring of packet buffers: ingress fills, processor edits/releases, egress drains.
// Optional sticky illegal-access flag on port err when FIELDBUF_ERR_EN is defined.
module field_buffer
    import fieldbuf_pkg::*;
#(
    parameter int unsigned NBUF         = FB_NBUF,
    parameter int unsigned NFIELD       = FB_NFIELD,
    parameter int unsigned buffer_width = FB_WIDTH,
    localparam int unsigned BW          = $clog2(NBUF),
    localparam int unsigned FW          = $clog2(NFIELD),
    localparam int unsigned LW          = FW + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [buffer_width-1:0] in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic [BW-1:0]           bufp,
    input  logic [FW-1:0]           fieldp,
    input  logic [FW-1:0]           fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    field_we,
    input  logic                    buf_release,
    output logic [buffer_width-1:0] field_in,
    output logic [NBUF-1:0]         buf_full,
    output logic                    out_valid,
    output logic [buffer_width-1:0] out_data,
    output logic                    out_last,
    input  logic                    out_ready
`ifdef FIELDBUF_ERR_EN
   ,output logic                    err
`endif
);

    buf_state_e        state_q [NBUF];
    buf_state_e        state_d [NBUF];
    logic [LW-1:0]     len_q   [NBUF];
    logic [LW-1:0]     len_d   [NBUF];
    logic [BW-1:0]     ibuf_q, ibuf_d, obuf_q, obuf_d;
    logic [FW-1:0]     iidx_q, iidx_d, oidx_q, oidx_d;
    logic              in_fire, out_fire, we_ok, rel_ok;
    logic [buffer_width-1:0] proc_rd;

    fieldbuf_mem #(
        .NBUF   (NBUF),
        .NFIELD (NFIELD),
        .WIDTH  (buffer_width)
    ) u_mem (
        .clk       (clk),
        .ing_we    (in_fire),
        .ing_buf   (ibuf_q),
        .ing_field (iidx_q),
        .ing_data  (in_data),
        .prc_we    (we_ok),
        .prc_buf   (bufp),
        .prc_field (fieldwp),
        .prc_data  (field_out),
        .prd_buf   (bufp),
        .prd_field (fieldp),
        .prd_data  (proc_rd),
        .egr_buf   (obuf_q),
        .egr_field (oidx_q),
        .egr_data  (out_data)
    );

    always_comb begin
        in_ready  = (state_q[ibuf_q] == BUF_EMPTY) || (state_q[ibuf_q] == BUF_FILLING);
        out_valid = (state_q[obuf_q] == BUF_DONE);
        out_last  = ({1'b0, oidx_q} == (len_q[obuf_q] - LW'(1)));
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        we_ok     = field_we && (state_q[bufp] == BUF_FULL) && ({1'b0, fieldwp} < len_q[bufp]);
        rel_ok    = buf_release && (state_q[bufp] == BUF_FULL);
        field_in  = ((state_q[bufp] == BUF_FULL) && ({1'b0, fieldp} < len_q[bufp])) ? proc_rd : '0;
        buf_full  = '0;
        for (int unsigned i = 0; i < NBUF; i++) begin
            buf_full[i] = (state_q[i] == BUF_FULL);
        end
    end

    // Ingress, release and egress each require a distinct source state, so
    // they can never collide on one buffer within a cycle.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ibuf_d  = ibuf_q;
        iidx_d  = iidx_q;
        obuf_d  = obuf_q;
        oidx_d  = oidx_q;
        if (in_fire) begin
            if (in_last || (iidx_q == FW'(NFIELD - 1))) begin
                state_d[ibuf_q] = BUF_FULL;
                len_d[ibuf_q]   = LW'(iidx_q) + LW'(1);
                iidx_d          = '0;
                ibuf_d          = (ibuf_q == BW'(NBUF - 1)) ? '0 : ibuf_q + BW'(1);
            end else begin
                state_d[ibuf_q] = BUF_FILLING;
                iidx_d          = iidx_q + FW'(1);
            end
        end
        if (rel_ok) begin
            state_d[bufp] = BUF_DONE;
        end
        if (out_fire) begin
            if (out_last) begin
                state_d[obuf_q] = BUF_EMPTY;
                oidx_d          = '0;
                obuf_d          = (obuf_q == BW'(NBUF - 1)) ? '0 : obuf_q + BW'(1);
            end else begin
                oidx_d          = oidx_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NBUF; i++) begin
                state_q[i] <= BUF_EMPTY;
                len_q[i]   <= '0;
            end
            ibuf_q <= '0;
            iidx_q <= '0;
            obuf_q <= '0;
            oidx_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NBUF; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
            end
            ibuf_q <= ibuf_d;
            iidx_q <= iidx_d;
            obuf_q <= obuf_d;
            oidx_q <= oidx_d;
        end
    end

`ifdef FIELDBUF_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (field_we && !we_ok) || (buf_release && !rel_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_field_buffer.sv
// Directed self-checking bench for field_buffer; covers the err port when
// FIELDBUF_ERR_EN is defined.
module tb_field_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_last, in_ready;
    logic [7:0] in_data;
    logic [2:0] bufp;
    logic [4:0] fieldp, fieldwp;
    logic [7:0] field_out, field_in;
    logic       field_we, buf_release;
    logic [7:0] buf_full;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
`ifdef FIELDBUF_ERR_EN
    logic       err;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;

    always #5 clk = ~clk;

    field_buffer #(
        .NBUF         (8),
        .NFIELD       (32),
        .buffer_width (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .bufp        (bufp),
        .fieldp      (fieldp),
        .fieldwp     (fieldwp),
        .field_out   (field_out),
        .field_we    (field_we),
        .buf_release (buf_release),
        .field_in    (field_in),
        .buf_full    (buf_full),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready)
`ifdef FIELDBUF_ERR_EN
       ,.err         (err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        field_we = 1'b0; buf_release = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int unsigned n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            in_valid = 1'b1; in_data = d; in_last = last;
            @(posedge clk);
            #1;
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    task automatic proc_op(input logic [2:0] b, input logic [4:0] f, input logic [7:0] d,
                           input logic we, input logic rel);
        @(negedge clk);
        bufp = b; fieldwp = f; field_out = d; field_we = we; buf_release = rel;
        @(posedge clk);
        #1;
        field_we = 1'b0; buf_release = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [2:0] b, input logic [4:0] f,
                            input logic [7:0] exp);
        @(negedge clk);
        bufp = b; fieldp = f;
        #1;
        check(tag, {24'd0, field_in}, {24'd0, exp});
    endtask

    // Each entry is {expected out_last, expected out_data}.
    task automatic drain(input string tag, input logic [8:0] exp[$]);
        int unsigned k = 0;
        int unsigned guard = 0;
        @(negedge clk);
        out_ready = 1'b1;
        while (k < exp.size() && guard < 500) begin
            if (out_valid) begin
                check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp[k][7:0]});
                check({tag, "_last"}, {31'd0, out_last}, {31'd0, exp[k][8]});
                k++;
            end
            guard++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (k < exp.size()) begin
            check({tag, "_timeout"}, k, exp.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] q[$];
        bufp = '0; fieldp = '0; fieldwp = '0; field_out = '0;
        rst_n = 1'b1;
        apply_reset();

        // reset values, sampled while rst_n is low
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_buf_full",  {24'd0, buf_full},  32'd0);
        check("rst_field_in",  {24'd0, field_in},  32'd0);
`ifdef FIELDBUF_ERR_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 5-byte packet into buffer 0
        for (int i = 0; i < 5; i++) send_byte(8'(11 + i), i == 4);
        check("pkt5_buf_full", {24'd0, buf_full}, 32'h01);
        read_chk("pkt5_f4", 3'd0, 5'd4, 8'd15);
        read_chk("pkt5_f5", 3'd0, 5'd5, 8'd0);
        read_chk("pkt5_f0", 3'd0, 5'd0, 8'd11);

        // processor edit, then release and drain
        proc_op(3'd0, 5'd2, 8'hAA, 1'b1, 1'b0);
        read_chk("edit_f2", 3'd0, 5'd2, 8'hAA);
`ifdef FIELDBUF_ERR_EN
        check("err_after_legal", {31'd0, err}, 32'd0);
`endif
        proc_op(3'd0, 5'd0, 8'h00, 1'b0, 1'b1);
        check("rel_out_valid", {31'd0, out_valid}, 32'd1);
        check("rel_buf_full",  {24'd0, buf_full},  32'h00);
        q = {};
        q.push_back({1'b0, 8'd11}); q.push_back({1'b0, 8'd12}); q.push_back({1'b0, 8'hAA});
        q.push_back({1'b0, 8'd14}); q.push_back({1'b1, 8'd15});
        drain("egr5", q);
        check("egr5_empty_valid", {31'd0, out_valid}, 32'd0);
        read_chk("egr5_f0_empty", 3'd0, 5'd0, 8'd0);

        // ignored accesses: write to EMPTY buffer 3, release of EMPTY buffer 1
        proc_op(3'd3, 5'd0, 8'h55, 1'b1, 1'b0);
        check("ign_we_buf_full", {24'd0, buf_full}, 32'h00);
`ifdef FIELDBUF_ERR_EN
        check("ign_we_err", {31'd0, err}, 32'd1);
`endif
        proc_op(3'd1, 5'd0, 8'h00, 1'b0, 1'b1);
        check("ign_rel_out_valid", {31'd0, out_valid}, 32'd0);

        // reset during a fill of buffer 2 and a drain of buffer 1
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b1);
        proc_op(3'd1, 5'd0, 8'h00, 1'b0, 1'b1);
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bufp = 3'd1; fieldp = 5'd0;
        #1;
        check("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_last",  {31'd0, out_last},  32'd0);
        check("mid_rst_buf_full",  {24'd0, buf_full},  32'd0);
        check("mid_rst_field_in",  {24'd0, field_in},  32'd0);
`ifdef FIELDBUF_ERR_EN
        check("mid_rst_err", {31'd0, err}, 32'd0);
`endif
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h77, 1'b1);
        check("post_rst_buf_full", {24'd0, buf_full}, 32'h01);
        read_chk("post_rst_f0", 3'd0, 5'd0, 8'h77);
        read_chk("post_rst_b1", 3'd1, 5'd0, 8'h00);

        // 40-byte packet spills from buffer 0 into buffer 1
        apply_reset();
        for (int i = 0; i < 40; i++) send_byte(8'(8'h40 + i), i == 39);
        check("pkt40_buf_full", {24'd0, buf_full}, 32'h03);
        read_chk("pkt40_b0_f31", 3'd0, 5'd31, 8'h5F);
        read_chk("pkt40_b1_f7",  3'd1, 5'd7,  8'h67);
        read_chk("pkt40_b1_f8",  3'd1, 5'd8,  8'h00);
        proc_op(3'd1, 5'd0, 8'h00, 1'b0, 1'b1);
        check("pkt40_order_hold", {31'd0, out_valid}, 32'd0);
        proc_op(3'd0, 5'd0, 8'h00, 1'b0, 1'b1);
        check("pkt40_out_valid", {31'd0, out_valid}, 32'd1);
        q = {};
        for (int i = 0; i < 40; i++) q.push_back({(i == 31 || i == 39) ? 1'b1 : 1'b0, 8'(8'h40 + i)});
        drain("egr40", q);
        check("egr40_buf_full", {24'd0, buf_full}, 32'h00);

        // fill every buffer, then free buffer 0
        apply_reset();
        for (int b = 0; b < 8; b++) send_byte(8'(8'h80 + b), 1'b1);
        check("all_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("all_full_buf_full", {24'd0, buf_full}, 32'hFF);
        proc_op(3'd0, 5'd0, 8'h00, 1'b0, 1'b1);
        q = {};
        q.push_back({1'b1, 8'h80});
        drain("egr_b0", q);
        check("freed_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h99, 1'b1);
        check("refill_buf_full", {24'd0, buf_full}, 32'hFF);
        check("refill_in_ready", {31'd0, in_ready}, 32'd0);
        read_chk("refill_b0_f0", 3'd0, 5'd0, 8'h99);

        // write and release in one cycle: the edited byte is what egresses
        proc_op(3'd1, 5'd0, 8'h5A, 1'b1, 1'b1);
        check("wr_rel_out_valid", {31'd0, out_valid}, 32'd1);
        check("wr_rel_out_data",  {24'd0, out_data},  32'h5A);
        check("wr_rel_out_last",  {31'd0, out_last},  32'd1);
        check("wr_rel_buf_full",  {24'd0, buf_full},  32'hFD);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
